// File: rtl/weight_buffer.sv
// Runtime-loaded kernel weight RAM with a fetch engine that streams one kernel
// out of a registered-read RAM into a flat word, weight 0 in the MSBs.
module weight_buffer #(
   parameter int unsigned DATA_W      = 8,
   parameter int unsigned KSIZE       = 5,
   parameter int unsigned NUM_KERNELS = 12
) (
   input  logic                                clk,
   input  logic                                rst_n,
   input  logic                                load_start,
   input  logic                                load_valid,
   input  logic signed [DATA_W-1:0]            load_data,
   output logic                                load_ready,
   output logic                                loaded,
   input  logic                                req_valid,
   input  logic [$clog2(NUM_KERNELS)-1:0]      req_kidx,
   output logic                                req_ready,
   output logic                                req_err,
   output logic                                kern_valid,
   input  logic                                kern_ready,
   output logic [DATA_W*KSIZE*KSIZE-1:0]       kern_flat
);

   localparam int unsigned KW    = KSIZE * KSIZE;
   localparam int unsigned DEPTH = NUM_KERNELS * KW;
   localparam int unsigned IW    = $clog2(NUM_KERNELS);
   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CW    = $clog2(KW + 1);
   localparam int unsigned FW    = DATA_W * KW;

   typedef enum logic [2:0] {EMPTY, LOAD, IDLE, FETCH, OUT} state_t;

   state_t                    state, state_nxt;
   logic [AW-1:0]             wr_ptr, wr_ptr_nxt;
   logic [AW-1:0]             base, base_nxt;
   logic [AW-1:0]             rd_addr_c;
   logic [CW-1:0]             cnt, cnt_nxt;
   logic                      loaded_nxt, load_ready_nxt, req_ready_nxt;
   logic                      req_err_nxt, kern_valid_nxt;
   logic                      wr_fire_c, req_fire_c, kidx_bad_c, last_word_c;
   logic                      rd_en_c, shift_c;
   logic signed [DATA_W-1:0]  mem [DEPTH];
   logic signed [DATA_W-1:0]  rd_data;

   assign wr_fire_c   = load_valid && load_ready;
   assign req_fire_c  = req_valid && req_ready;
   // Zero-extended compare so a power-of-two kernel count cannot wrap to 0
   assign kidx_bad_c  = {1'b0, req_kidx} >= (IW + 1)'(NUM_KERNELS);
   assign last_word_c = (wr_ptr == AW'(DEPTH - 1));
   assign rd_en_c     = (state == FETCH) && (cnt < CW'(KW));
   // Read data lags the address by one cycle, so capture starts at cnt=1
   assign shift_c     = (state == FETCH) && (cnt != '0);
   assign rd_addr_c   = base + AW'(cnt);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= EMPTY;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (load_start) state_nxt = LOAD;
         LOAD:  if (wr_fire_c && last_word_c) state_nxt = IDLE;
         IDLE: begin
            if (load_start)                      state_nxt = LOAD;
            else if (req_fire_c && !kidx_bad_c)  state_nxt = FETCH;
         end
         FETCH: if (cnt == CW'(KW)) state_nxt = OUT;
         OUT:   if (kern_ready) state_nxt = IDLE;
         default: state_nxt = EMPTY;
      endcase
   end

   always_comb begin
      loaded_nxt     = loaded;
      wr_ptr_nxt     = wr_ptr;
      base_nxt       = base;
      cnt_nxt        = '0;
      req_err_nxt    = 1'b0;
      load_ready_nxt = (state_nxt == LOAD);
      req_ready_nxt  = (state_nxt == IDLE);
      kern_valid_nxt = (state_nxt == OUT);
      case (state)
         EMPTY: begin
            if (load_start) begin
               loaded_nxt = 1'b0;
               wr_ptr_nxt = '0;
            end
         end
         IDLE: begin
            if (load_start) begin
               loaded_nxt = 1'b0;
               wr_ptr_nxt = '0;
            end else if (req_fire_c) begin
               if (kidx_bad_c) req_err_nxt = 1'b1;
               else            base_nxt    = AW'(req_kidx) * AW'(KW);
            end
         end
         LOAD: begin
            if (wr_fire_c) begin
               wr_ptr_nxt = wr_ptr + 1'b1;
               if (last_word_c) loaded_nxt = 1'b1;
            end
         end
         FETCH: cnt_nxt = cnt + 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         loaded     <= 1'b0;
         load_ready <= 1'b0;
         req_ready  <= 1'b0;
         req_err    <= 1'b0;
         kern_valid <= 1'b0;
         kern_flat  <= '0;
         wr_ptr     <= '0;
         base       <= '0;
         cnt        <= '0;
      end else begin
         loaded     <= loaded_nxt;
         load_ready <= load_ready_nxt;
         req_ready  <= req_ready_nxt;
         req_err    <= req_err_nxt;
         kern_valid <= kern_valid_nxt;
         wr_ptr     <= wr_ptr_nxt;
         base       <= base_nxt;
         cnt        <= cnt_nxt;
         if (shift_c) kern_flat <= {kern_flat[FW-DATA_W-1:0], rd_data};
      end
   end

   // Weight storage: contents are not reset and are only trusted after a reload
   always_ff @(posedge clk) begin
      if (wr_fire_c) mem[wr_ptr] <= load_data;
      if (rd_en_c)   rd_data     <= mem[rd_addr_c];
   end

endmodule

// File: tb/tb_weight_buffer.sv
// Randomized self-checking bench for weight_buffer against an array model of
// the weight memory and the kernel layout rules.
module tb_weight_buffer;

   localparam int unsigned DATA_W      = 8;
   localparam int unsigned KSIZE       = 5;
   localparam int unsigned NUM_KERNELS = 12;
   localparam int unsigned KW          = KSIZE * KSIZE;
   localparam int unsigned DEPTH       = NUM_KERNELS * KW;
   localparam int unsigned IW          = $clog2(NUM_KERNELS);
   localparam int unsigned FW          = DATA_W * KW;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              load_start = 1'b0;
   logic              load_valid = 1'b0;
   logic [DATA_W-1:0] load_data = '0;
   logic              load_ready;
   logic              loaded;
   logic              req_valid = 1'b0;
   logic [IW-1:0]     req_kidx = '0;
   logic              req_ready;
   logic              req_err;
   logic              kern_valid;
   logic              kern_ready = 1'b0;
   logic [FW-1:0]     kern_flat;

   int errors = 0;
   int checks = 0;
   logic [DATA_W-1:0] model_mem [DEPTH];

   weight_buffer #(.DATA_W(DATA_W), .KSIZE(KSIZE), .NUM_KERNELS(NUM_KERNELS)) dut (
      .clk(clk), .rst_n(rst_n),
      .load_start(load_start), .load_valid(load_valid), .load_data(load_data),
      .load_ready(load_ready), .loaded(loaded),
      .req_valid(req_valid), .req_kidx(req_kidx), .req_ready(req_ready), .req_err(req_err),
      .kern_valid(kern_valid), .kern_ready(kern_ready), .kern_flat(kern_flat)
   );

   always #5 clk = ~clk;

   function automatic logic [FW-1:0] exp_kernel(input int k);
      logic [FW-1:0] v;
      v = '0;
      for (int j = 0; j < int'(KW); j++)
         v[(int'(KW) - 1 - j) * int'(DATA_W) +: DATA_W] = model_mem[k * int'(KW) + j];
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req_ready(input string name);
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s req_ready_timeout: req_ready=%b required 1", name, req_ready);
      end
   endtask

   // Full reload: optional random bubbles, either address-mod-128 or random words
   task automatic do_load(input bit gaps, input bit pattern);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      checks++;
      if (load_ready !== 1'b1 || loaded !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL load_enter: load_ready=%b loaded=%b req_ready=%b required 1 0 0",
                  load_ready, loaded, req_ready);
      end
      for (int i = 0; i < int'(DEPTH); i++) begin
         if (gaps) begin
            int g = int'($urandom_range(0, 2));
            for (int b = 0; b < g; b++) begin
               load_valid = 1'b0;
               load_data  = DATA_W'($urandom);
               tick();
            end
         end
         load_valid = 1'b1;
         load_data  = pattern ? DATA_W'(i % 128) : DATA_W'($urandom);
         model_mem[i] = load_data;
         tick();
         if (i == int'(DEPTH) - 2) begin
            checks++;
            if (loaded !== 1'b0 || load_ready !== 1'b1) begin
               errors++;
               $display("FAIL load_penultimate: loaded=%b load_ready=%b required 0 1",
                        loaded, load_ready);
            end
         end
      end
      load_valid = 1'b0;
      checks++;
      if (loaded !== 1'b1 || load_ready !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL load_done: loaded=%b load_ready=%b req_ready=%b required 1 0 1",
                  loaded, load_ready, req_ready);
      end
   endtask

   // Fetch kernel k, optionally stall the consumer and inject load_start mid-fetch
   task automatic do_fetch(input int k, input int stall, input int inject);
      int n;
      bit seen;
      logic [FW-1:0] exp;
      wait_req_ready("fetch");
      req_valid = 1'b1;
      req_kidx  = IW'(k);
      tick();
      req_valid = 1'b0;
      checks++;
      if (req_ready !== 1'b0 || req_err !== 1'b0) begin
         errors++;
         $display("FAIL fetch_accept k=%0d: req_ready=%b req_err=%b required 0 0", k, req_ready, req_err);
      end
      seen = 1'b0;
      for (n = 1; n <= 60; n++) begin
         if (n == inject) begin
            load_start = 1'b1;
            load_valid = 1'b1;
            load_data  = DATA_W'($urandom);
         end
         tick();
         load_start = 1'b0;
         load_valid = 1'b0;
         if (kern_valid === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      checks++;
      if (!seen || n != int'(KW) + 1) begin
         errors++;
         $display("FAIL fetch_latency k=%0d: edges=%0d required %0d", k, n, KW + 1);
      end
      exp = exp_kernel(k);
      checks++;
      if (kern_flat !== exp) begin
         errors++;
         $display("FAIL fetch_data k=%0d: got %h required %h", k, kern_flat, exp);
      end
      for (int s = 0; s < stall; s++) begin
         tick();
         checks++;
         if (kern_valid !== 1'b1 || req_ready !== 1'b0 || kern_flat !== exp) begin
            errors++;
            $display("FAIL fetch_stall cyc=%0d: kern_valid=%b req_ready=%b flat=%h required 1 0 %h",
                     s, kern_valid, req_ready, kern_flat, exp);
         end
      end
      kern_ready = 1'b1;
      tick();
      kern_ready = 1'b0;
      checks++;
      if (kern_valid !== 1'b0 || req_ready !== 1'b1 || kern_flat !== exp ||
          loaded !== 1'b1 || load_ready !== 1'b0) begin
         errors++;
         $display("FAIL fetch_handshake k=%0d: kv=%b rr=%b loaded=%b lr=%b flat=%h required 0 1 1 0 %h",
                  k, kern_valid, req_ready, loaded, load_ready, kern_flat, exp);
      end
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++;
      if (loaded !== 1'b0 || load_ready !== 1'b0 || req_ready !== 1'b0 ||
          req_err !== 1'b0 || kern_valid !== 1'b0 || kern_flat !== '0) begin
         errors++;
         $display("FAIL reset_values: loaded=%b lr=%b rr=%b err=%b kv=%b flat=%h required all 0",
                  loaded, load_ready, req_ready, req_err, kern_valid, kern_flat);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if (load_ready !== 1'b0 || req_ready !== 1'b0 || loaded !== 1'b0) begin
         errors++;
         $display("FAIL reset_empty: lr=%b rr=%b loaded=%b required 0 0 0", load_ready, req_ready, loaded);
      end
   endtask

   task automatic test_fetch_k3();
      do_fetch(3, 0, -1);
      checks++;
      if (kern_flat[FW-1 -: DATA_W] !== 8'h4B || kern_flat[DATA_W-1:0] !== 8'h63) begin
         errors++;
         $display("FAIL fetch_k3_bytes: msb=%h lsb=%h required 4b 63",
                  kern_flat[FW-1 -: DATA_W], kern_flat[DATA_W-1:0]);
      end
   endtask

   task automatic test_bad_index();
      logic [FW-1:0] prev;
      int bad [2] = '{12, 15};
      prev = kern_flat;
      foreach (bad[b]) begin
         wait_req_ready("bad_index");
         req_valid = 1'b1;
         req_kidx  = IW'(bad[b]);
         tick();
         req_valid = 1'b0;
         checks++;
         if (req_err !== 1'b1 || req_ready !== 1'b1 || kern_valid !== 1'b0 || kern_flat !== prev) begin
            errors++;
            $display("FAIL bad_index_pulse k=%0d: err=%b rr=%b kv=%b flat=%h required 1 1 0 %h",
                     bad[b], req_err, req_ready, kern_valid, kern_flat, prev);
         end
         tick();
         checks++;
         if (req_err !== 1'b0 || req_ready !== 1'b1 || kern_valid !== 1'b0) begin
            errors++;
            $display("FAIL bad_index_after k=%0d: err=%b rr=%b kv=%b required 0 1 0",
                     bad[b], req_err, req_ready, kern_valid);
         end
      end
      do_fetch(int'(NUM_KERNELS) - 1, 0, -1);
   endtask

   task automatic test_back_to_back();
      int ka, kb, n, seen_at;
      logic [FW-1:0] expa;
      ka = int'($urandom_range(0, NUM_KERNELS - 1));
      kb = int'($urandom_range(0, NUM_KERNELS - 1));
      expa = exp_kernel(ka);
      wait_req_ready("b2b");
      req_valid  = 1'b1;
      req_kidx   = IW'(ka);
      kern_ready = 1'b1;
      tick();
      req_kidx = IW'(kb);
      seen_at  = 0;
      for (n = 1; n <= 100; n++) begin
         tick();
         if (kern_valid === 1'b1) begin
            seen_at = n;
            checks++;
            if (kern_flat !== expa || req_ready !== 1'b0) begin
               errors++;
               $display("FAIL b2b_first k=%0d: flat=%h rr=%b required %h 0", ka, kern_flat, req_ready, expa);
            end
         end
         if (req_ready === 1'b1) break;
      end
      checks++;
      if (seen_at != int'(KW) + 1) begin
         errors++;
         $display("FAIL b2b_first_latency: edges=%0d required %0d", seen_at, KW + 1);
      end
      tick();
      req_valid  = 1'b0;
      kern_ready = 1'b0;
      checks++;
      if (req_ready !== 1'b0 || req_err !== 1'b0 || n + 1 < int'(KW) + 3) begin
         errors++;
         $display("FAIL b2b_second_accept: rr=%b err=%b spacing=%0d required 0 0 >=%0d",
                  req_ready, req_err, n + 1, KW + 3);
      end
      seen_at = 0;
      for (int m = 1; m <= 60; m++) begin
         tick();
         if (kern_valid === 1'b1) begin
            seen_at = m;
            break;
         end
      end
      checks++;
      if (seen_at != int'(KW) + 1 || kern_flat !== exp_kernel(kb)) begin
         errors++;
         $display("FAIL b2b_second k=%0d: edges=%0d flat=%h required %0d %h",
                  kb, seen_at, kern_flat, KW + 1, exp_kernel(kb));
      end
      kern_ready = 1'b1;
      tick();
      kern_ready = 1'b0;
   endtask

   task automatic test_gaps_stall();
      do_load(1'b1, 1'b0);
      // Words offered while load_ready=0 must be dropped
      for (int i = 0; i < 5; i++) begin
         load_valid = 1'b1;
         load_data  = DATA_W'($urandom);
         tick();
      end
      load_valid = 1'b0;
      do_fetch(int'($urandom_range(1, NUM_KERNELS - 2)), 10, -1);
      do_fetch(0, 0, -1);
      do_fetch(int'(NUM_KERNELS) - 1, 3, -1);
   endtask

   task automatic test_load_during_fetch();
      do_fetch(int'($urandom_range(0, NUM_KERNELS - 1)), 2, 6);
      do_fetch(int'($urandom_range(0, NUM_KERNELS - 1)), 0, 20);
   endtask

   task automatic test_reset_mid_fetch();
      wait_req_ready("reset_mid_fetch");
      req_valid = 1'b1;
      req_kidx  = IW'(2);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (kern_valid !== 1'b0 || kern_flat !== '0 || req_ready !== 1'b0 || loaded !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid_fetch: kv=%b flat=%h rr=%b loaded=%b required 0 0 0 0",
                  kern_valid, kern_flat, req_ready, loaded);
      end
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_load();
      do_load(1'b0, 1'b1);
      do_fetch(7, 0, -1);
      load_start = 1'b1;
      tick();
      load_start = 1'b0;
      for (int i = 0; i < 150; i++) begin
         load_valid = 1'b1;
         load_data  = DATA_W'($urandom);
         tick();
      end
      load_data = DATA_W'($urandom);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (loaded !== 1'b0 || load_ready !== 1'b0 || req_ready !== 1'b0 ||
          req_err !== 1'b0 || kern_valid !== 1'b0 || kern_flat !== '0) begin
         errors++;
         $display("FAIL reset_mid_load: loaded=%b lr=%b rr=%b err=%b kv=%b flat=%h required all 0",
                  loaded, load_ready, req_ready, req_err, kern_valid, kern_flat);
      end
      load_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      req_valid = 1'b1;
      req_kidx  = '0;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++;
         if (req_err !== 1'b0 || req_ready !== 1'b0 || kern_valid !== 1'b0 ||
             loaded !== 1'b0 || load_ready !== 1'b0) begin
            errors++;
            $display("FAIL empty_ignores_req cyc=%0d: err=%b rr=%b kv=%b loaded=%b lr=%b required 0",
                     i, req_err, req_ready, kern_valid, loaded, load_ready);
         end
      end
      req_valid = 1'b0;
      do_load(1'b0, 1'b1);
      do_fetch(0, 0, -1);
      checks++;
      if (kern_flat[FW-1 -: DATA_W] !== 8'h00 || kern_flat[DATA_W-1:0] !== 8'h18) begin
         errors++;
         $display("FAIL reload_k0_bytes: msb=%h lsb=%h required 00 18",
                  kern_flat[FW-1 -: DATA_W], kern_flat[DATA_W-1:0]);
      end
   endtask

   initial begin
      test_reset();
      do_load(1'b0, 1'b1);
      test_fetch_k3();
      test_bad_index();
      test_back_to_back();
      test_gaps_stall();
      test_load_during_fetch();
      test_reset_mid_fetch();
      test_reset_mid_load();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/weight_buffer.md
WEIGHT_BUFFER -- requirements
Module: weight_buffer

Interface
REQ-001 Parameter DATA_W, 8, bit width of one signed weight.
REQ-002 Parameter KSIZE, 5, kernel side; KW = KSIZE*KSIZE weights per kernel (derived).
REQ-003 Parameter NUM_KERNELS, 12, kernels stored (e.g. 3 layer-1 + 9 layer-2); DEPTH = NUM_KERNELS*KW (derived); IW = $clog2(NUM_KERNELS) (derived).
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 load_start  in  1  pulse that begins a full reload.
REQ-008 load_valid  in  1  load word valid.
REQ-009 load_data  in  DATA_W  load word, signed.
REQ-010 load_ready  out  1  block accepts a load word.
REQ-011 loaded  out  1  memory holds a complete weight set.
REQ-012 req_valid  in  1  kernel fetch request.
REQ-013 req_kidx  in  IW  requested kernel index.
REQ-014 req_ready  out  1  block accepts a request.
REQ-015 req_err  out  1  one-cycle pulse flagging a rejected out-of-range index.
REQ-016 kern_valid  out  1  kern_flat holds a complete kernel.
REQ-017 kern_ready  in  1  consumer accepts kern_flat.
REQ-018 kern_flat  out  DATA_W*KW  fetched kernel, flattened.

Function
REQ-019 Storage SHALL be a DEPTH x DATA_W RAM with one write port and one registered (1-cycle) read port, replacing fixed initial contents with runtime load.
REQ-020 The FSM SHALL have states EMPTY, LOAD, IDLE, FETCH, OUT, with EMPTY entered on reset.
REQ-021 From EMPTY or IDLE, load_start SHALL go to LOAD, clear the write pointer to 0, and drive loaded to 0 on the next edge.
REQ-022 load_start in LOAD, FETCH or OUT SHALL be ignored.
REQ-023 load_ready SHALL be 1 only in LOAD.
REQ-024 A word SHALL be written when load_valid && load_ready, at address = write pointer, after which the pointer increments by 1.
REQ-025 On accepting word DEPTH-1, the FSM SHALL go to IDLE, set loaded to 1, and deassert load_ready on the next cycle.
REQ-026 load_valid bubbles SHALL stall loading without loss, and words with load_ready=0 SHALL be dropped.
REQ-027 req_ready SHALL be 1 only in IDLE, and a request SHALL be accepted on req_valid && req_ready.
REQ-028 On accepting req_kidx >= NUM_KERNELS, the block SHALL pulse req_err for exactly one cycle, stay in IDLE, and leave kern_flat unchanged.
REQ-029 On accepting a valid index, the block SHALL go to FETCH and issue read addresses req_kidx*KW + j for j = 0..KW-1, one per cycle.
REQ-030 Weight j SHALL be placed at kern_flat[(KW-1-j)*DATA_W +: DATA_W], so weight 0 sits in the MSBs.
REQ-031 kern_valid SHALL rise exactly KW+1 rising edges after the accepting edge, with the FSM in OUT.
REQ-032 In OUT, kern_valid and kern_flat SHALL hold stable until kern_ready=1; on that edge the FSM SHALL go to IDLE and kern_valid SHALL fall.
REQ-033 kern_flat SHALL retain the last kernel after the handshake.
REQ-034 req_valid held during OUT SHALL be accepted no earlier than the first IDLE cycle, and back-to-back fetches SHALL therefore cost at least KW+3 cycles.
REQ-035 Index multiply SHALL use at least $clog2(DEPTH) bits with no truncation.

Reset
REQ-036 Asserting rst_n=0 at any time, including mid-LOAD or mid-FETCH, SHALL immediately force EMPTY, loaded=0, load_ready=0, req_ready=0, req_err=0, kern_valid=0, kern_flat=0, and clear all pointers and counters.
REQ-037 RAM contents after reset SHALL be treated as invalid, and a full reload SHALL be required before any fetch.
REQ-038 In EMPTY, req_valid SHALL be ignored with no req_err.

Verification
REQ-039 Reset release, load_start, then 300 words with value = address mod 128 (DATA_W=8, KSIZE=5, NUM_KERNELS=12) -> loaded=1 after word 299, load_ready=0 the cycle after.
REQ-040 Fetch kidx=3 after REQ-039 -> kern_valid exactly 26 edges after accept; kern_flat MSB byte = 75 (0x4B), LSB byte = 99 (0x63).
REQ-041 Fetch kidx=12 -> single-cycle req_err, req_ready remains 1, kern_valid=0, kern_flat unchanged.
REQ-042 Randomized load_valid gaps plus kern_ready held 0 for 10 cycles in OUT -> no lost words; kern_flat stable across the stall; req_ready=0 throughout OUT.
REQ-043 rst_n pulsed low during word 150 of a load -> loaded=0 and state EMPTY; req_valid ignored; a subsequent full reload and fetch of kidx=0 -> bytes 0..24 in MSB-first order.
REQ-044 load_start asserted during FETCH -> ignored; the fetch completes with correct data, and loaded stays 1.
